// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex 7-segment driver. Scans one digit per dwell
// period on the clken strobe, with a blank tick between digits.
module seg7_scan #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DWELL      = 2,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clken,
  input  logic                enable,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp,
  input  logic                lz_blank,
  output logic [6:0]          seg,
  output logic                dp_out,
  output logic [DIGITS-1:0]   an,
  output logic                frame
);

  localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW  = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
  localparam logic        OFF = (ACTIVE_LOW != 0);

  typedef enum logic {BLANK, ON} phase_t;

  phase_t              phase, phase_next;
  logic [IW-1:0]       idx, idx_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [4*DIGITS-1:0] sval, sval_next;
  logic [DIGITS-1:0]   sdp, sdp_next;
  logic                frame_next;
  logic [6:0]          seg_on, seg_next;
  logic                dp_on, dp_next;
  logic [DIGITS-1:0]   an_on, an_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    phase_next = phase;
    idx_next   = idx;
    cnt_next   = cnt;
    sval_next  = sval;
    sdp_next   = sdp;
    frame_next = 1'b0;
    if (!enable) begin
      phase_next = BLANK;
      idx_next   = '0;
      cnt_next   = '0;
    end else if (clken) begin
      case (phase)
        BLANK: begin
          phase_next = ON;
          cnt_next   = '0;
          // shadow loads only at frame start so a frame never tears
          if (idx == '0) begin
            sval_next = value;
            sdp_next  = dp;
          end
        end
        default: begin
          if (cnt == CW'(DWELL - 1)) begin
            phase_next = BLANK;
            cnt_next   = '0;
            if (idx == IW'(DIGITS - 1)) begin
              idx_next   = '0;
              frame_next = 1'b1;
            end else begin
              idx_next = idx + 1'b1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      endcase
    end

    // outputs are decoded from next state so they change on the same edge
    seg_on = '0;
    dp_on  = 1'b0;
    an_on  = '0;
    if (phase_next == ON) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx_next == IW'(i)) begin
          an_on[i] = 1'b1;
          dp_on    = sdp_next[i];
          if (!(i != 0 && lz_blank && (sval_next >> (4 * i)) == '0))
            seg_on = hex7(sval_next[4*i +: 4]);
        end
      end
    end
    seg_next = {7{OFF}} ^ seg_on;
    dp_next  = OFF ^ dp_on;
    an_next  = {DIGITS{OFF}} ^ an_on;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase  <= BLANK;
      idx    <= '0;
      cnt    <= '0;
      sval   <= '0;
      sdp    <= '0;
      frame  <= 1'b0;
      seg    <= {7{OFF}};
      dp_out <= OFF;
      an     <= {DIGITS{OFF}};
    end else begin
      phase  <= phase_next;
      idx    <= idx_next;
      cnt    <= cnt_next;
      sval   <= sval_next;
      sdp    <= sdp_next;
      frame  <= frame_next;
      seg    <= seg_next;
      dp_out <= dp_next;
      an     <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: tick-count model of the scan checked every cycle against an
// active-high and an active-low instance, plus directed literal checks.
module tb_seg7_scan;

  localparam int unsigned DIGITS       = 4;
  localparam int unsigned DWELL        = 2;
  localparam int unsigned FRAME        = DIGITS * (DWELL + 1);
  localparam int unsigned CLK_PER_TICK = 4;

  logic        clock = 1'b0;
  logic        reset, clken, enable, lz_blank;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  seg0, seg1;
  logic        dpo0, dpo1, frame0, frame1;
  logic [3:0]  an0, an1;

  always #5 clock = ~clock;

  seg7_scan #(.DIGITS(DIGITS), .DWELL(DWELL), .ACTIVE_LOW(0)) dut0 (
    .clock(clock), .reset(reset), .clken(clken), .enable(enable), .value(value),
    .dp(dp), .lz_blank(lz_blank), .seg(seg0), .dp_out(dpo0), .an(an0), .frame(frame0));

  seg7_scan #(.DIGITS(DIGITS), .DWELL(DWELL), .ACTIVE_LOW(1)) dut1 (
    .clock(clock), .reset(reset), .clken(clken), .enable(enable), .value(value),
    .dp(dp), .lz_blank(lz_blank), .seg(seg1), .dp_out(dpo1), .an(an1), .frame(frame1));

  // Model: ticks elapsed since scan start, modulo frame length.
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int unsigned m_n = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;
  logic        m_frame = 1'b0;

  always @(posedge clock) begin
    m_lz <= lz_blank;
    if (reset) begin
      m_n <= 0; m_val <= '0; m_dp <= '0; m_frame <= 1'b0;
    end else if (!enable) begin
      m_n <= 0; m_frame <= 1'b0;
    end else if (clken) begin
      m_n     <= (m_n + 1) % FRAME;
      m_frame <= ((m_n + 1) % FRAME) == 0;
      if (m_n == 0) begin
        m_val <= value;
        m_dp  <= dp;
      end
    end else begin
      m_frame <= 1'b0;
    end
  end

  function automatic logic [12:0] model_out();
    logic [3:0]  a;
    logic [6:0]  s;
    logic        d;
    logic [15:0] upper;
    logic [3:0]  nib;
    int unsigned k;
    a = '0; s = '0; d = 1'b0;
    if (m_n % (DWELL + 1) != 0) begin
      k     = m_n / (DWELL + 1);
      a[k]  = 1'b1;
      d     = m_dp[k];
      upper = m_val >> (4 * k);
      nib   = upper[3:0];
      if (!(k > 0 && m_lz && upper == 16'h0)) s = hex_tab[nib];
    end
    return {a, s, d, m_frame};
  endfunction

  int frame_seen = 0;
  always @(posedge clock) if (frame0 === 1'b1) frame_seen <= frame_seen + 1;

  int          checks = 0;
  int          errors = 0;
  logic        checking = 1'b0;
  logic        dir_valid = 1'b0;
  int          dir_kind = 0;
  logic [15:0] dir_exp = '0;
  string       dir_name = "";

  always @(negedge clock) begin : compare
    logic [12:0] e, e1;
    logic [15:0] act;
    if (checking) begin
      e  = model_out();
      e1 = {~e[12:9], ~e[8:2], ~e[1], e[0]};
      checks++;
      if ({an0, seg0, dpo0, frame0} !== e) begin
        errors++;
        $display("FAIL scan_high t=%0t an/seg/dp/frame got %b/%h/%b/%b want %b/%h/%b/%b", $time,
                 an0, seg0, dpo0, frame0, e[12:9], e[8:2], e[1], e[0]);
      end
      checks++;
      if ({an1, seg1, dpo1, frame1} !== e1) begin
        errors++;
        $display("FAIL scan_low t=%0t an/seg/dp/frame got %b/%h/%b/%b want %b/%h/%b/%b", $time,
                 an1, seg1, dpo1, frame1, e1[12:9], e1[8:2], e1[1], e1[0]);
      end
      checks++;
      if ($countones(an0) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t an got %b want at most one bit set", $time, an0);
      end
    end
    if (dir_valid) begin
      case (dir_kind)
        0:       act = {3'b000, an0, seg0, dpo0, frame0};
        1:       act = {3'b000, an1, seg1, dpo1, frame1};
        default: act = 16'(frame_seen);
      endcase
      checks++;
      if (act !== dir_exp) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h", dir_name, $time, act, dir_exp);
      end
    end
  end

  task automatic expect_vec(input int kind, input logic [15:0] v, input string name);
    dir_kind = kind; dir_exp = v; dir_name = name; dir_valid = 1'b1;
    @(negedge clock); #1;
    dir_valid = 1'b0;
  endtask

  task automatic show(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    expect_vec(0, {3'b000, a, s, d, 1'b0}, name);
  endtask

  task automatic tick();
    clken = 1'b1;
    @(posedge clock); #1;
    clken = 1'b0;
    repeat (CLK_PER_TICK - 1) begin @(posedge clock); #1; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : stim
    int base;
    reset = 1'b1; enable = 1'b0; clken = 1'b0; lz_blank = 1'b0; value = '0; dp = '0;
    @(posedge clock); #1;
    checking = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    expect_vec(0, 16'h0000, "reset_high");
    expect_vec(1, {3'b000, 4'hF, 7'h7F, 1'b1, 1'b0}, "reset_low");

    // basic scan of 12AF
    enable = 1'b1; value = 16'h12AF; dp = 4'b0100;
    base = frame_seen;
    tick();     show("d0_F", 4'b0001, 7'h71, 1'b0);
    tick();     show("d0_F_dwell", 4'b0001, 7'h71, 1'b0);
    tick();     show("gap0", 4'b0000, 7'h00, 1'b0);
    tick();     show("d1_A", 4'b0010, 7'h77, 1'b0);
    ticks(3);   show("d2_2_dp", 4'b0100, 7'h5B, 1'b1);
    ticks(3);   show("d3_1", 4'b1000, 7'h06, 1'b0);
    ticks(2);   expect_vec(2, 16'(base + 1), "frame_once");

    // value change mid-frame appears only at next frame start
    ticks(7);   show("d2_before", 4'b0100, 7'h5B, 1'b1);
    value = 16'h0003;
    tick();     show("d2_old", 4'b0100, 7'h5B, 1'b1);
    ticks(2);   show("d3_old", 4'b1000, 7'h06, 1'b0);
    ticks(3);   show("d0_new", 4'b0001, 7'h4F, 1'b0);
    ticks(3);   show("d1_new_zero", 4'b0010, 7'h3F, 1'b0);

    // leading-zero blanking
    lz_blank = 1'b1; value = 16'h0050; dp = 4'b0000;
    ticks(9);   show("lz_d0", 4'b0001, 7'h3F, 1'b0);
    ticks(3);   show("lz_d1", 4'b0010, 7'h6D, 1'b0);
    ticks(3);   show("lz_d2", 4'b0100, 7'h00, 1'b0);
    ticks(3);   show("lz_d3", 4'b1000, 7'h00, 1'b0);
    value = 16'h0000;
    ticks(3);   show("lz_zero_d0", 4'b0001, 7'h3F, 1'b0);
    ticks(3);   show("lz_zero_d1", 4'b0010, 7'h00, 1'b0);

    // enable dropped mid-ON, then re-enabled
    lz_blank = 1'b0; enable = 1'b0;
    @(posedge clock); #1;
    show("en_off", 4'b0000, 7'h00, 1'b0);
    tick();     show("en_off_tick", 4'b0000, 7'h00, 1'b0);
    value = 16'hABCD; enable = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    show("reen_blank", 4'b0000, 7'h00, 1'b0);
    tick();     show("reen_d0", 4'b0001, 7'h5E, 1'b0);

    // reset on the edge that would have ended the frame
    ticks(10);  show("d3_pre_reset", 4'b1000, 7'h77, 1'b0);
    base = frame_seen;
    reset = 1'b1; clken = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; clken = 1'b0;
    expect_vec(1, {3'b000, 4'hF, 7'h7F, 1'b1, 1'b0}, "midscan_reset_low");
    show("midscan_reset_high", 4'b0000, 7'h00, 1'b0);
    repeat (3) begin @(posedge clock); #1; end
    expect_vec(2, 16'(base), "no_aborted_frame");

    // clken held high: one tick per clock
    base = frame_seen;
    clken = 1'b1;
    repeat (12) begin @(posedge clock); #1; end
    expect_vec(0, 16'h0001, "cont_frame_pulse");
    show("cont_d0", 4'b0001, 7'h5E, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    expect_vec(2, 16'(base + 1), "cont_frame_count");
    clken = 1'b0;
    repeat (2) begin @(posedge clock); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

- Multiplexed hex 7-segment display driver; output-side counterpart to the switch debouncer.
- Takes clean internal values and drives a common-segment LED display so a human can read them.
- Scans one digit at a time off the same 1 ms `clken` strobe, with a blanking gap between digits to suppress ghosting.
- Latches its input once per frame so a digit never tears mid-scan; sits between the output/register datapath and the board's display pins.

## Interface
- `DIGITS`, 4: number of digits; ≥1.
- `DWELL`, 2: clken ticks each digit stays lit; ≥1.
- `ACTIVE_LOW`, 1: 1 = `seg`/`dp_out`/`an` active-low, 0 = active-high. "Inactive" below means the off level under this setting.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `clken`  in  1  one-clock-wide scan strobe (nominally 1 ms).
- `enable`  in  1  0 = display dark and scan held at start.
- `value`  in  4*DIGITS  nibble i = digit i; digit 0 = rightmost.
- `dp`  in  DIGITS  decimal point per digit.
- `lz_blank`  in  1  1 = suppress leading zeros.
- `seg`  out  7  segments; `seg[0]`=a … `seg[6]`=g.
- `dp_out`  out  1  decimal-point segment.
- `an`  out  DIGITS  digit enables; at most one active.
- `frame`  out  1  one-clock pulse per completed scan.

## Operation
- State: phase {BLANK, ON}, digit index `idx` (0..DIGITS-1), dwell counter `cnt`, shadow register `shadow` (value + dp).
- All state changes happen only on edges with `clken`=1, except reset and enable=0.
- BLANK → ON:
  - Occurs after exactly one clken tick in BLANK.
  - If `idx`=0, `shadow` loads `value` and `dp` on this edge, and digit 0 displays the newly loaded data.
- ON → BLANK:
  - Occurs on the DWELL-th clken tick in ON.
  - `idx` becomes (idx+1) mod DIGITS.
  - If the wrap goes to 0, `frame`=1 for exactly that one clock.
- In ON:
  - `an[idx]` active, all other anodes inactive.
  - `seg` = hex decode of `shadow` nibble `idx`; `dp_out` = `shadow` dp bit `idx`.
- In BLANK: all of `an`, `seg`, `dp_out` inactive.
- Hex decode (active-high, bits g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW inverts.
- Leading-zero blanking:
  - Applies when `lz_blank`=1, to digit i>0 whose `shadow` nibbles i..DIGITS-1 are all zero.
  - Such a digit has `seg` inactive, but `an` and `dp_out` behave normally.
  - Digit 0 is never blanked.
  - `lz_blank` is sampled live, not shadowed.
- enable=0 (any clock, clken ignored):
  - Next edge forces BLANK, `idx`=0, `cnt`=0; outputs inactive; no `frame`; `shadow` retained.
  - On re-enable, the scan proceeds exactly as after reset.

## Timing
- Reset values: phase BLANK, `idx`=0, `cnt`=0, `shadow`=0, `frame`=0; `an`, `seg`, `dp_out` inactive.
- All outputs are registered and change on the same edge as the state transition that defines them.
- Frame period = DIGITS×(DWELL+1) clken ticks. Duty per digit = DWELL/(DIGITS×(DWELL+1)).
- `value`/`dp` changes are visible only from the next frame start; latency is at most one frame plus one clock.
- `clken` held high continuously: each clock counts as one tick; behaviour stays consistent.
- Reset or enable=0 mid-ON: outputs go inactive on the next edge and no partial `frame` is emitted. Reset has priority over enable.
- Counter widths: `cnt` = $clog2(DWELL+1) bits; `idx` = $clog2(DIGITS) bits (min 1).

## Test plan
Bench settings: DIGITS=4, DWELL=2, ACTIVE_LOW=0, clken every 4 clocks unless stated.

1. Reset, then enable=1, value=16'h12AF, dp=4'b0100 → sequence over ticks:
   - an=0001/seg=71 for 2 ticks, then an=0000 for 1 tick.
   - an=0010/seg=77, blank, an=0100/seg=5B/dp_out=1, blank, an=1000/seg=06.
   - `frame` pulses once every 12 ticks.
2. Change `value` to 16'h0003 while digit 2 is lit → old digits finish the frame; the new value appears starting at the next digit 0 (seg=4F).
3. lz_blank=1, value=16'h0050 →
   - digits 3 and 2 have an active, seg=00.
   - digit 1 seg=6D; digit 0 seg=3F.
   - With value=0, only digit 0 shows 3F.
4. Drop enable mid-ON of digit 1 → next clock an=0000, seg=00, no frame. Re-enable → BLANK one tick, then digit 0, `shadow` reloaded.
5. Assert reset mid-scan with ACTIVE_LOW=1 → next clock an=1111, seg=7F, dp_out=1, shadow=0; `frame` never pulses for the aborted frame.
6. clken tied high → full frame in 12 clocks; `frame` is exactly one clock wide; never more than one `an` bit is active at any time.
